gate_delay_meter: RTL

GATE_DELAY_METER -- requirements
Module: gate_delay_meter

---
 rtl/gate_delay_pkg.sv | 18 +
 rtl/gate_delay_meter_if.sv | 34 +++
 rtl/gate_delay_meter_sat_counter.sv | 22 ++
 rtl/gate_delay_meter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/gate_delay_pkg.sv
// Shared types and default parameters for the gate delay meter.
//   state_t      : measurement FSM states (IDLE, WAIT)
//   DEF_*        : default counter width, acceptance window and timeout
//   PASS_W       : width of the pass counter
package gate_delay_pkg;

    localparam int unsigned DEF_CW      = 8;
    localparam int unsigned DEF_MIN_DLY = 4;
    localparam int unsigned DEF_MAX_DLY = 6;
    localparam int unsigned DEF_TIMEOUT = 20;
    localparam int unsigned PASS_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/gate_delay_meter_if.sv
// Stimulus / measurement bundle of the gate delay meter.
//   stim_evt, exp_val, dut_out : stimulus side (driven by master)
//   meas_*, pass_cnt           : measurement results (driven by slave)
interface gate_delay_meter_if
    import gate_delay_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) ();

    logic              stim_evt;
    logic              exp_val;
    logic              dut_out;
    logic              meas_valid;
    logic [CW-1:0]     meas_delay;
    logic              meas_rise;
    logic              meas_early;
    logic              meas_late;
    logic              meas_tmo;
    logic              meas_abort;
    logic [PASS_W-1:0] pass_cnt;

    modport master (
        output stim_evt, exp_val, dut_out,
        input  meas_valid, meas_delay, meas_rise, meas_early, meas_late,
               meas_tmo, meas_abort, pass_cnt
    );

    modport slave (
        input  stim_evt, exp_val, dut_out,
        output meas_valid, meas_delay, meas_rise, meas_early, meas_late,
               meas_tmo, meas_abort, pass_cnt
    );

endinterface

// File: rtl/gate_delay_meter_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count enable
//   count    : current value, holds at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/gate_delay_meter.sv
// Measures the response delay of a gate after each stimulus event and
// classifies it against a [MIN_DLY, MAX_DLY] window with a timeout.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stimulus inputs and registered measurement outputs
module gate_delay_meter
    import gate_delay_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned MIN_DLY = DEF_MIN_DLY,
    parameter int unsigned MAX_DLY = DEF_MAX_DLY,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    gate_delay_meter_if.slave   bus
);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              exp_q, exp_d;
    logic              valid_q, valid_d;
    logic [CW-1:0]     delay_q, delay_d;
    logic              rise_q, rise_d;
    logic              early_q, early_d;
    logic              late_q, late_d;
    logic              tmo_q, tmo_d;
    logic              abort_q, abort_d;
    logic              pass_d;
    logic              match;
    logic [PASS_W-1:0] pass_cnt;

    // State, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            valid_q <= 1'b0;
            delay_q <= '0;
            rise_q  <= 1'b0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            tmo_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            valid_q <= valid_d;
            delay_q <= delay_d;
            rise_q  <= rise_d;
            early_q <= early_d;
            late_q  <= late_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end

    // Next state; a new stimulus in WAIT wins over both match and timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        abort_d = 1'b0;
        pass_d  = 1'b0;
        delay_d = delay_q;
        rise_d  = rise_q;
        early_d = early_q;
        late_d  = late_q;
        cnt_inc = cnt_q + CW'(1);
        match   = (bus.dut_out == exp_q);

        case (state_q)
            IDLE: begin
                if (bus.stim_evt) begin
                    exp_d   = bus.exp_val;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.stim_evt) begin
                    abort_d = 1'b1;
                    exp_d   = bus.exp_val;
                    cnt_d   = '0;
                end else if (match || (cnt_inc == CW'(TIMEOUT))) begin
                    // On timeout cnt_inc equals TIMEOUT, so it is the reported delay too
                    valid_d = 1'b1;
                    tmo_d   = !match;
                    delay_d = cnt_inc;
                    rise_d  = exp_q;
                    early_d = match && (cnt_inc < CW'(MIN_DLY));
                    late_d  = match && (cnt_inc > CW'(MAX_DLY));
                    pass_d  = match && (cnt_inc >= CW'(MIN_DLY))
                                    && (cnt_inc <= CW'(MAX_DLY));
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count in-window results, updated on the same edge as meas_valid
    sat_counter #(
        .W (PASS_W)
    ) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pass_d),
        .count (pass_cnt)
    );

    assign bus.meas_valid = valid_q;
    assign bus.meas_delay = delay_q;
    assign bus.meas_rise  = rise_q;
    assign bus.meas_early = early_q;
    assign bus.meas_late  = late_q;
    assign bus.meas_tmo   = tmo_q;
    assign bus.meas_abort = abort_q;
    assign bus.pass_cnt   = pass_cnt;

endmodule
